// File: rtl/rgb_fader_pkg.sv
// Shared constants for the RGB PWM fader: mode encodings and the RGBA driver
// current settings used wherever SB_RGBA_DRV is instantiated next to the fader.
package rgb_fader_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_RAMP    = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_STATIC  = 2'd3;

    // Half-current mode keeps the LEDs comfortable to look at on the dev board.
    localparam RGBA_CURRENT_MODE = "0b1";
    localparam RGB0_CURRENT      = "0b000011";
    localparam RGB1_CURRENT      = "0b000011";
    localparam RGB2_CURRENT      = "0b000011";

endpackage

// File: rtl/rgb_fade_gen.sv
// Fade-level generator: prescaler, sawtooth/triangle level stepping and the
// end-of-cycle strobe. Held at its idle state while clear is high.
module rgb_fade_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 600000,
    parameter int PS_BITS  = 24
) (
    input  logic                clki,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    input  logic                breathe,
    output logic [PWM_BITS-1:0] level,
    output logic                cycle_end,
    output logic                cycle_pulse
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);
    localparam logic [PS_BITS-1:0]  PS_LAST   = PS_BITS'(PRESCALE - 1);
    localparam logic [PS_BITS-1:0]  PS_ONE    = PS_BITS'(1);

    logic [PS_BITS-1:0]  ps_reg, ps_next;
    logic [PWM_BITS-1:0] level_reg, level_next;
    logic                dir_down_reg, dir_down_next;
    logic                cycle_reg;
    logic                tick;

    always_comb begin
        tick          = enable && !clear && (ps_reg == PS_LAST);
        ps_next       = ps_reg;
        level_next    = level_reg;
        dir_down_next = dir_down_reg;
        cycle_end     = 1'b0;
        if (clear) begin
            ps_next       = '0;
            level_next    = '0;
            dir_down_next = 1'b0;
        end else if (enable) begin
            ps_next = tick ? '0 : ps_reg + PS_ONE;
            if (tick) begin
                if (!breathe) begin
                    if (level_reg == LEVEL_MAX) begin
                        level_next = '0;
                        cycle_end  = 1'b1;
                    end else begin
                        level_next = level_reg + LEVEL_ONE;
                    end
                end else if (!dir_down_reg) begin
                    // Turn around at the top without repeating MAX.
                    if (level_reg == LEVEL_MAX) begin
                        level_next    = LEVEL_MAX - LEVEL_ONE;
                        dir_down_next = 1'b1;
                    end else begin
                        level_next = level_reg + LEVEL_ONE;
                    end
                end else begin
                    if (level_reg == LEVEL_ONE) begin
                        level_next    = '0;
                        dir_down_next = 1'b0;
                        cycle_end     = 1'b1;
                    end else begin
                        level_next = level_reg - LEVEL_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            ps_reg       <= '0;
            level_reg    <= '0;
            dir_down_reg <= 1'b0;
            cycle_reg    <= 1'b0;
        end else begin
            ps_reg       <= ps_next;
            level_reg    <= level_next;
            dir_down_reg <= dir_down_next;
            cycle_reg    <= cycle_end;
        end
    end

    assign level       = level_reg;
    assign cycle_pulse = cycle_reg;

endmodule

// File: rtl/rgb_fader.sv
// N-channel LED PWM fader: mode control, colour-mask sequencing, shared PWM
// counter and per-channel registered comparators feeding the RGBA driver.
module rgb_fader
    import rgb_fader_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 600000,
    parameter int PS_BITS  = 24
) (
    input  logic                clki,
    input  logic                rst,
    input  logic [1:0]          mode_i,
    input  logic                pause_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [NCH-1:0]      colour_i,
    output logic [NCH-1:0]      pwm_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic [NCH-1:0]      mask_o,
    output logic                cycle_o
);

    localparam logic [NCH-1:0]      MASK_ONE  = NCH'(1);
    localparam logic [NCH-1:0]      MASK_ALL  = '1;
    localparam logic [PWM_BITS-1:0] COUNT_ONE = PWM_BITS'(1);

    logic [1:0]          mode_reg, mode_next;
    logic [NCH-1:0]      fade_mask_reg, fade_mask_next;
    logic [PWM_BITS-1:0] static_level_reg;
    logic [NCH-1:0]      static_mask_reg;
    logic [PWM_BITS-1:0] pwmcnt_reg;
    logic [NCH-1:0]      pwm_reg, pwm_next;

    logic                fading;
    logic                off_req;
    logic                gen_clear;
    logic                gen_enable;
    logic [PWM_BITS-1:0] gen_level;
    logic                cycle_end;
    logic                cycle_pulse;
    logic [PWM_BITS-1:0] level_sel;
    logic [NCH-1:0]      mask_sel;

    assign fading  = (mode_reg == MODE_RAMP) || (mode_reg == MODE_BREATHE);
    assign off_req = (mode_i == MODE_OFF);

    // Requesting OFF while fading blanks the generator on the same edge the mode drops.
    assign gen_clear  = !fading || off_req;
    assign gen_enable = fading && !pause_i;

    rgb_fade_gen #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE),
        .PS_BITS  (PS_BITS)
    ) u_fade_gen (
        .clki        (clki),
        .rst         (rst),
        .clear       (gen_clear),
        .enable      (gen_enable),
        .breathe     (mode_reg == MODE_BREATHE),
        .level       (gen_level),
        .cycle_end   (cycle_end),
        .cycle_pulse (cycle_pulse)
    );

    always_comb begin
        mode_next      = mode_reg;
        fade_mask_next = fade_mask_reg;
        if (!fading) begin
            mode_next = mode_i;
        end else if (off_req) begin
            mode_next = MODE_OFF;
        end else if (cycle_end) begin
            mode_next = mode_i;
        end
        if (cycle_end) begin
            fade_mask_next = (fade_mask_reg == MASK_ALL) ? MASK_ONE : fade_mask_reg + MASK_ONE;
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            mode_reg         <= MODE_OFF;
            fade_mask_reg    <= MASK_ONE;
            static_level_reg <= '0;
            static_mask_reg  <= '0;
            pwmcnt_reg       <= '0;
            pwm_reg          <= '0;
        end else begin
            mode_reg         <= mode_next;
            fade_mask_reg    <= fade_mask_next;
            static_level_reg <= duty_i;
            static_mask_reg  <= colour_i;
            pwmcnt_reg       <= pwmcnt_reg + COUNT_ONE;
            pwm_reg          <= pwm_next;
        end
    end

    // STATIC keeps its own level/colour so the fade mask survives a detour through it.
    assign level_sel = (mode_reg == MODE_STATIC) ? static_level_reg : gen_level;
    assign mask_sel  = (mode_reg == MODE_STATIC) ? static_mask_reg  : fade_mask_reg;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_pwm
        assign pwm_next[gi] = (pwmcnt_reg < level_sel) && mask_sel[gi];
    end

    assign pwm_o   = pwm_reg;
    assign level_o = level_sel;
    assign mask_o  = mask_sel;
    assign cycle_o = cycle_pulse;

endmodule

// File: tb/tb_rgb_fader.sv
// Directed bench for rgb_fader: expected level/mask/cycle steps are queued as
// stimulus is applied and popped whenever level_o moves.
module tb_rgb_fader;
    import rgb_fader_pkg::*;

    localparam int NCH      = 3;
    localparam int PWM_BITS = 3;
    localparam int PRESCALE = 4;
    localparam int PS_BITS  = 4;

    logic                clki = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          mode_i = MODE_OFF;
    logic                pause_i = 1'b0;
    logic [PWM_BITS-1:0] duty_i = '0;
    logic [NCH-1:0]      colour_i = '0;
    logic [NCH-1:0]      pwm_o;
    logic [PWM_BITS-1:0] level_o;
    logic [NCH-1:0]      mask_o;
    logic                cycle_o;

    typedef struct {
        logic [2:0] level;
        logic [2:0] mask;
        logic       cyc;
        int         gap;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle_count = 0;
    logic [2:0] exp_mask;

    rgb_fader #(
        .NCH      (NCH),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE),
        .PS_BITS  (PS_BITS)
    ) dut (
        .clki     (clki),
        .rst      (rst),
        .mode_i   (mode_i),
        .pause_i  (pause_i),
        .duty_i   (duty_i),
        .colour_i (colour_i),
        .pwm_o    (pwm_o),
        .level_o  (level_o),
        .mask_o   (mask_o),
        .cycle_o  (cycle_o)
    );

    always #5 clki = ~clki;

    always @(negedge clki) begin
        #1;
        if (cycle_o === 1'b1) cycle_count++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] next_mask(input logic [2:0] m);
        return (m == 3'b111) ? 3'b001 : m + 3'b001;
    endfunction

    function automatic void push(input logic [2:0] lvl, input logic [2:0] msk, input logic cyc, input int gap);
        exp_q.push_back(exp_t'{lvl, msk, cyc, gap});
    endfunction

    task automatic wait_level_change(output int cycles);
        logic [2:0] prev;
        prev   = level_o;
        cycles = 0;
        do begin
            @(negedge clki);
            cycles++;
        end while (level_o === prev && cycles < 64);
    endtask

    task automatic run_steps(input string name, input int n);
        int   gap;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            wait_level_change(gap);
            if (exp_q.size() == 0) begin
                check($sformatf("%s_queue_empty[%0d]", name, k), exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_level[%0d]", name, k), level_o, e.level);
                check($sformatf("%s_mask[%0d]", name, k), mask_o, e.mask);
                check($sformatf("%s_cycle[%0d]", name, k), cycle_o, e.cyc);
                if (e.gap != 0) check($sformatf("%s_gap[%0d]", name, k), gap, e.gap);
            end
        end
    endtask

    task automatic count_pwm(input int n, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clki);
            c0 += int'(pwm_o[0]);
            c1 += int'(pwm_o[1]);
            c2 += int'(pwm_o[2]);
        end
    endtask

    initial begin
        int c0, c1, c2;
        int cyc_base;

        // Reset and idle OFF
        repeat (3) @(posedge clki);
        @(negedge clki);
        check("reset_pwm", pwm_o, 3'b000);
        check("reset_level", level_o, 0);
        check("reset_mask", mask_o, 3'b001);
        check("reset_cycle", cycle_o, 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clki);
            check("off_idle_level", level_o, 0);
            check("off_idle_pwm", pwm_o, 3'b000);
        end

        // RAMP: seven full sawtooth cycles walk the mask 001..111 and back to 001
        exp_mask = 3'b001;
        for (int c = 0; c < 7; c++) begin
            for (int l = 1; l <= 7; l++) push(3'(l), exp_mask, 1'b0, (c == 0 && l == 1) ? 5 : 4);
            exp_mask = next_mask(exp_mask);
            push(3'd0, exp_mask, 1'b1, 4);
        end
        mode_i = MODE_RAMP;
        run_steps("ramp", 56);
        check("ramp_mask_wrapped", mask_o, 3'b001);
        @(negedge clki);
        check("ramp_cycle_one_shot", cycle_o, 0);

        // RAMP -> BREATHE request at level 4 waits for the ramp to wrap
        for (int l = 1; l <= 4; l++) push(3'(l), exp_mask, 1'b0, (l == 1) ? 3 : 4);
        run_steps("ramp_pre", 4);
        mode_i = MODE_BREATHE;
        for (int l = 5; l <= 7; l++) push(3'(l), exp_mask, 1'b0, 4);
        exp_mask = next_mask(exp_mask);
        push(3'd0, exp_mask, 1'b1, 4);
        run_steps("ramp_tail", 4);

        // BREATHE: triangle 1..7..1,0 with a single cycle pulse
        for (int l = 1; l <= 7; l++) push(3'(l), exp_mask, 1'b0, 4);
        for (int l = 6; l >= 1; l--) push(3'(l), exp_mask, 1'b0, 4);
        exp_mask = next_mask(exp_mask);
        push(3'd0, exp_mask, 1'b1, 4);
        run_steps("breathe", 1);
        cyc_base = cycle_count;
        run_steps("breathe", 13);
        @(negedge clki);
        check("breathe_cycle_pulses", cycle_count - cyc_base, 1);
        check("breathe_cycle_low", cycle_o, 0);

        // BREATHE -> OFF at level 4 blanks within two cycles
        for (int l = 1; l <= 4; l++) push(3'(l), exp_mask, 1'b0, (l == 1) ? 3 : 4);
        run_steps("breathe_pre_off", 4);
        mode_i = MODE_OFF;
        @(negedge clki);
        @(negedge clki);
        check("off_blank_level", level_o, 0);
        check("off_blank_pwm", pwm_o, 3'b000);
        check("off_mask_kept", mask_o, exp_mask);
        cyc_base = cycle_count;
        for (int k = 0; k < 4; k++) begin
            @(negedge clki);
            check("off_hold_level", level_o, 0);
            check("off_hold_pwm", pwm_o, 3'b000);
        end

        // STATIC duty/colour
        mode_i   = MODE_STATIC;
        duty_i   = 3'd3;
        colour_i = 3'b101;
        repeat (3) @(negedge clki);
        check("static_level", level_o, 3);
        check("static_mask", mask_o, 3'b101);
        count_pwm(16, c0, c1, c2);
        check("static_d3_ch0", c0, 6);
        check("static_d3_ch1", c1, 0);
        check("static_d3_ch2", c2, 6);
        duty_i = 3'd7;
        repeat (3) @(negedge clki);
        count_pwm(8, c0, c1, c2);
        check("static_d7_ch0", c0, 7);
        check("static_d7_ch1", c1, 0);
        check("static_d7_ch2", c2, 7);
        duty_i = 3'd0;
        repeat (3) @(negedge clki);
        count_pwm(8, c0, c1, c2);
        check("static_d0_ch0", c0, 0);
        check("static_d0_ch1", c1, 0);
        check("static_d0_ch2", c2, 0);
        check("static_no_cycle", cycle_count - cyc_base, 0);

        // RAMP with a 20-cycle pause at level 3
        for (int l = 1; l <= 3; l++) push(3'(l), exp_mask, 1'b0, (l == 1) ? 5 : 4);
        mode_i = MODE_RAMP;
        run_steps("pause_pre", 3);
        pause_i = 1'b1;
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clki);
            check($sformatf("pause_level[%0d]", k), level_o, 3);
            check($sformatf("pause_mask[%0d]", k), mask_o, exp_mask);
            if (k <= 16) begin
                c0 += int'(pwm_o[0]);
                c1 += int'(pwm_o[1]);
                c2 += int'(pwm_o[2]);
            end
            if (k == 20) pause_i = 1'b0;
        end
        check("pause_pwm_ch0", c0, 6);
        check("pause_pwm_ch1", c1, 6);
        check("pause_pwm_ch2", c2, 0);
        push(3'd4, exp_mask, 1'b0, 4);
        run_steps("pause_resume", 1);

        // Into BREATHE, then reset mid-cycle
        mode_i = MODE_BREATHE;
        for (int l = 5; l <= 7; l++) push(3'(l), exp_mask, 1'b0, 4);
        exp_mask = next_mask(exp_mask);
        push(3'd0, exp_mask, 1'b1, 4);
        for (int l = 1; l <= 2; l++) push(3'(l), exp_mask, 1'b0, 4);
        run_steps("pre_reset", 6);
        rst    = 1'b1;
        mode_i = MODE_OFF;
        @(negedge clki);
        check("midrst_pwm", pwm_o, 3'b000);
        check("midrst_level", level_o, 0);
        check("midrst_mask", mask_o, 3'b001);
        check("midrst_cycle", cycle_o, 0);
        rst = 1'b0;
        repeat (6) @(negedge clki);
        check("post_rst_level", level_o, 0);
        check("post_rst_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
